// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type and slot constants for the single-byte I2C write master.
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START_C, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP_C} state_e;
  localparam int SLOTS_FULL = 20;
  localparam int SLOTS_NACK = 11;
  localparam int QUARTERS = 4;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: divides the system clock into quarter bit-slots; one-cycle tick on each quarter's last cycle.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && cnt_q == LAST;
    cnt_d = (!en || cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_master_writer.sv
// i2c_master_writer: single-byte I2C write (START, addr+W, ACK, data, ACK, STOP).
// All outputs are flops loaded from the next-state view, so they change exactly at slot/quarter entry.
module i2c_master_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [6:0] ADDR,
  input  logic [7:0] DATA,
  input  logic       RX,
  output logic       TX,
  output logic       SCL,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR
);
  import i2c_pkg::*;
  localparam int QW = $clog2(QUARTERS);
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTERS - 1);
  state_e        state_q, state_d;
  logic [QW-1:0] qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic          ack_err_q, ack_err_d, tx_q, tx_d, scl_q, scl_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          tick, slot_end, scl_high;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  assign slot_end = tick && qtr_q == Q_LAST;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      qtr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ack_err_q <= 1'b0;
      tx_q      <= 1'b1;
      scl_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      tx_q      <= tx_d;
      scl_q     <= scl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Address byte and data byte share one shift register: {A6..A0, W=0, D7..D0}
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    if (state_q == IDLE) begin
      if (START) begin
        state_d   = START_C;
        qtr_d     = '0;
        bit_d     = '0;
        shift_d   = {ADDR, 1'b0, DATA};
        ack_err_d = 1'b0;
      end
    end else if (tick) begin
      qtr_d = qtr_q + QW'(1);
      if ((state_q == ADDR_ACK || state_q == DATA_ACK) && qtr_q == QW'(2))
        ack_err_d = ack_err_q | RX;
      if (slot_end) begin
        bit_d = '0;
        case (state_q)
          START_C:       state_d = i2c_pkg::ADDR;
          i2c_pkg::ADDR: begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? ADDR_ACK : i2c_pkg::ADDR;
          end
          ADDR_ACK:      state_d = ack_err_q ? STOP_C : i2c_pkg::DATA;
          i2c_pkg::DATA: begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? DATA_ACK : i2c_pkg::DATA;
          end
          DATA_ACK:      state_d = STOP_C;
          STOP_C:        state_d = IDLE;
          default:       state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    scl_high = qtr_d == QW'(1) || qtr_d == QW'(2);
    tx_d     = 1'b1;
    scl_d    = 1'b1;
    case (state_d)
      START_C:                      tx_d = qtr_d < QW'(2);
      i2c_pkg::ADDR, i2c_pkg::DATA: begin
        tx_d  = shift_d[15];
        scl_d = scl_high;
      end
      ADDR_ACK, DATA_ACK:           scl_d = scl_high;
      STOP_C:                       begin
        tx_d  = qtr_d == Q_LAST;
        scl_d = qtr_d != '0;
      end
      default:                      ;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_q == STOP_C && slot_end;
  end

  assign TX      = tx_q;
  assign SCL     = scl_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ACK_ERR = ack_err_q;
endmodule
